// File: rtl/matrix_mem.sv
// matrix_mem: playfield bit matrix that OR-merges 4x4 shapes; TETRIS_LINE_CLEAR_EN adds full-row removal
module matrix_mem #(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [15:0]                 mm_write_addr_i,
  input  logic [3:0][3:0]             mm_write_data_i,
  input  logic                        mm_write_v_i,
  output logic                        mm_is_ready_o,
  input  logic [$clog2(height_p)-1:0] rd_row_i,
  output logic [width_p-1:0]          rd_data_o,
  output logic [2:0]                  lines_cleared_o,
  output logic                        lines_cleared_v_o
);
  localparam int hw = $clog2(height_p);
  typedef enum logic [1:0] {eIDLE, eMERGE, eCLEAR} state_e;
  state_e state_q, state_n;
  logic [width_p-1:0] mat_q [height_p];
  logic [7:0] x_q, y_q;
  logic [3:0][3:0] shape_q;
  logic [1:0] r_q;
  logic accept;
  logic [9:0] row_t;
  logic row_ok;
  logic [width_p-1:0] mask;
  assign accept = mm_write_v_i && state_q == eIDLE;
  assign mm_is_ready_o = state_q == eIDLE;
  assign row_t = {{2{y_q[7]}}, y_q} + {8'd0, r_q};
  assign row_ok = !row_t[9] && row_t < 10'(height_p);
  assign rd_data_o = ({1'b0, rd_row_i} < (hw+1)'(height_p)) ? mat_q[rd_row_i] : '0;
  // column j takes shape bit j-x when that offset lands inside the 4-wide shape; no wrap possible
  for (genvar j = 0; j < width_p; j++) begin : g_mask
    logic [9:0] d;
    assign d = 10'(j) - {{2{x_q[7]}}, x_q};
    assign mask[j] = d[9:2] == 8'd0 && shape_q[r_q][d[1:0]];
  end
`ifdef TETRIS_LINE_CLEAR_EN
  localparam state_e merge_exit = eCLEAR;
  logic [hw:0] src_q, dst_q;
  logic [2:0] cnt_q, lines_q;
  logic lines_v_q, scan, full, clr_done;
  assign scan = !src_q[hw];
  assign full = &mat_q[src_q[hw-1:0]];
  assign clr_done = scan ? (src_q == '0 && !full && dst_q == '0) : dst_q == '0;
  assign lines_cleared_o = lines_q;
  assign lines_cleared_v_o = lines_v_q;
`else
  localparam state_e merge_exit = eIDLE;
  assign lines_cleared_o = 3'd0;
  assign lines_cleared_v_o = 1'b0;
`endif
  // next-state: merge runs four rows, then optionally compacts the matrix
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      eIDLE:   state_n = accept ? eMERGE : eIDLE;
      eMERGE:  state_n = r_q == 2'd3 ? merge_exit : eMERGE;
`ifdef TETRIS_LINE_CLEAR_EN
      eCLEAR:  state_n = clr_done ? eIDLE : eCLEAR;
`endif
      default: state_n = eIDLE;
    endcase
  end
  // control registers: state, captured request, merge row counter
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= eIDLE;
      x_q <= '0;
      y_q <= '0;
      shape_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_n;
      r_q <= state_q == eMERGE ? r_q + 2'd1 : 2'd0;
      if (accept) begin
        x_q <= mm_write_addr_i[15:8];
        y_q <= mm_write_addr_i[7:0];
        shape_q <= mm_write_data_i;
      end
    end
  end
`ifdef TETRIS_LINE_CLEAR_EN
  // clear scan: source walks bottom-up, destination only advances past kept rows
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      src_q <= (hw+1)'(height_p - 1);
      dst_q <= (hw+1)'(height_p - 1);
      cnt_q <= '0;
      lines_q <= '0;
      lines_v_q <= 1'b0;
    end else begin
      src_q <= state_q != eCLEAR ? (hw+1)'(height_p - 1) : scan ? src_q - 1'b1 : src_q;
      dst_q <= state_q != eCLEAR ? (hw+1)'(height_p - 1) : (scan && full) ? dst_q : dst_q - 1'b1;
      cnt_q <= state_q != eCLEAR ? 3'd0 : cnt_q + {2'd0, scan && full};
      lines_v_q <= state_q == eCLEAR && clr_done;
      if (state_q == eCLEAR && clr_done) lines_q <= cnt_q;
    end
  end
`endif
  // matrix storage: OR-merge one shape row per cycle, or move/zero one row during clear
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < height_p; i++) mat_q[i] <= '0;
    end else if (state_q == eMERGE && row_ok) begin
      mat_q[row_t[hw-1:0]] <= mat_q[row_t[hw-1:0]] | mask;
    end
`ifdef TETRIS_LINE_CLEAR_EN
    else if (state_q == eCLEAR && !(scan && full)) begin
      mat_q[dst_q[hw-1:0]] <= scan ? mat_q[src_q[hw-1:0]] : '0;
    end
`endif
  end
endmodule

// File: tb/tb_matrix_mem.sv
// tb_matrix_mem: scoreboard bench for matrix_mem (default 16x32), both with and without TETRIS_LINE_CLEAR_EN
module tb_matrix_mem;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [15:0] mm_write_addr_i = '0;
  logic [3:0][3:0] mm_write_data_i = '0;
  logic mm_write_v_i = 1'b0;
  logic mm_is_ready_o;
  logic [4:0] rd_row_i = '0;
  logic [15:0] rd_data_o;
  logic [2:0] lines_cleared_o;
  logic lines_cleared_v_o;
  matrix_mem dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .mm_write_addr_i(mm_write_addr_i), .mm_write_data_i(mm_write_data_i),
    .mm_write_v_i(mm_write_v_i), .mm_is_ready_o(mm_is_ready_o),
    .rd_row_i(rd_row_i), .rd_data_o(rd_data_o),
    .lines_cleared_o(lines_cleared_o), .lines_cleared_v_o(lines_cleared_v_o)
  );
  always #50 clk_i = ~clk_i;
`ifdef TETRIS_LINE_CLEAR_EN
  localparam bit clr = 1'b1;
`else
  localparam bit clr = 1'b0;
`endif
  typedef struct packed {
    logic [31:0][15:0] m;
    logic [7:0] busy;
    logic [2:0] lines;
    logic [1:0] pulses;
  } exp_t;
  exp_t q[$];
  logic [31:0][15:0] em;
  int n_cmp = 0, n_bad = 0;
  logic mon_prev = 1'b0;
  int mon_busy = 0, mon_pulses = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic push(input logic [7:0] busy, input logic [2:0] lines, input logic [1:0] pulses);
    exp_t e;
    e.m = em;
    e.busy = busy;
    e.lines = lines;
    e.pulses = pulses;
    q.push_back(e);
  endtask
  function automatic logic [7:0] bsy(input int lines);
    return clr ? 8'(36 + lines) : 8'd4;
  endfunction
  task automatic wait_ready();
    int n = 0;
    @(negedge clk_i);
    while (!mm_is_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!mm_is_ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: timed out, ready=%0b expected 1", mm_is_ready_o);
    end
  endtask
  task automatic wr(input logic [7:0] x, input logic [7:0] y, input logic [15:0] d);
    wait_ready();
    mm_write_addr_i = {x, y};
    mm_write_data_i = d;
    mm_write_v_i = 1'b1;
    @(posedge clk_i);
    #1 mm_write_v_i = 1'b0;
  endtask
  // monitor: each ready rising edge closes an operation; sweep all rows and compare with the next expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (lines_cleared_v_o) mon_pulses++;
      if (!mm_is_ready_o) mon_busy++;
      else if (!mon_prev) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL completion: got unexpected completion, expected none");
        end else begin
          e = q.pop_front();
          for (int i = 0; i < 32; i++) begin
            rd_row_i = 5'(i);
            #1 chk($sformatf("row%0d", i), 32'(rd_data_o), 32'(e.m[i]));
          end
          if (e.busy != 8'hFF) chk("busy_cycles", mon_busy, 32'(e.busy));
          chk("lines_cleared", 32'(lines_cleared_o), 32'(e.lines));
          chk("clear_pulses", mon_pulses, 32'(e.pulses));
        end
        mon_busy = 0;
        mon_pulses = 0;
      end
      mon_prev = mm_is_ready_o;
    end
  end
  initial begin
    em = '0;
    push(8'hFF, 3'd0, 2'd0);
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", 32'(mm_is_ready_o), 32'd1);
    em[0] |= 16'h000F;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd0, 8'd0, 16'h000F);
    em[30] |= 16'hC000;
    em[31] |= 16'hC000;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd14, 8'd30, 16'hFFFF);
    em[0] |= 16'h0003;
    em[1] |= 16'h0003;
    em[2] |= 16'h0003;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'hFE, 8'hFF, 16'hFFFF);
    em[10] |= 16'h00F0;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd4, 8'd10, 16'h000F);
    @(negedge clk_i);
    mm_write_addr_i = {8'd0, 8'd20};
    mm_write_data_i = 16'hFFFF;
    mm_write_v_i = 1'b1;
    @(posedge clk_i);
    #1 mm_write_v_i = 1'b0;
    em[31] |= 16'h00F0;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd4, 8'd31, 16'h000F);
    em[31] |= 16'h0F00;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd8, 8'd31, 16'h000F);
    em[31] |= 16'hF000;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd12, 8'd31, 16'h000F);
`ifdef TETRIS_LINE_CLEAR_EN
    for (int k = 31; k > 0; k--) em[k] = em[k-1];
    em[0] = '0;
    push(bsy(1), 3'd1, 2'd1);
`else
    em[31] |= 16'h000F;
    push(bsy(0), 3'd0, 2'd0);
`endif
    wr(8'd0, 8'd31, 16'h000F);
    wr(8'd0, 8'd5, 16'hFFFF);
    em = '0;
    push(8'hFF, 3'd0, 2'd0);
    @(posedge clk_i);
    #2 reset_ni = 1'b0;
    #20 reset_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset_release", 32'(mm_is_ready_o), 32'd1);
    em[0] = 16'h000F;
    push(bsy(0), 3'd0, 2'(clr));
    wr(8'd0, 8'd0, 16'h000F);
    wait_ready();
    repeat (3) @(negedge clk_i);
    chk("pending_expectations", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
